// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small decode helpers used by the top level.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10
  } state_e;

  // Divides have op[1] set; multiplies have it clear.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed variants (MULT, DIV) have op[0] clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Combinational conditional two's-complement negate. Used both to take operand
// magnitudes at issue and to restore result signs in the SIGN state.
module muldiv_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? ({W{1'b0}} - val) : val;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the execute
// stage. One radix-2 step per cycle on a shared 2*WIDTH accumulator: right
// shift-add for multiply, left shift restoring-subtract for divide.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies are computed in one shot
// at issue and skip the iterative CALC phase.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e                 state, state_nxt;
  logic [1:0]             op_r;
  logic                   neg_q;
  logic                   neg_r;
  logic [WIDTH-1:0]       dsr;
  logic [2*WIDTH-1:0]     acc;
  logic [CNT_W-1:0]       cnt;

  logic                   issue;
  logic                   sgn_op;
  logic                   sa, sb;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic                   fast_mul;

  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_nxt;
  logic [WIDTH:0]         rem_sh;
  logic [WIDTH-1:0]       rem_sub;
  logic                   div_ok;
  logic [2*WIDTH-1:0]     div_nxt;

  logic [2*WIDTH-1:0]     prod_res;
  logic [WIDTH-1:0]       quo_res;
  logic [WIDTH-1:0]       rem_res;

  assign issue  = (state == ST_IDLE) & start & ~flush;
  assign stall  = (state != ST_IDLE) | issue;

  // Operand sign flags only matter for the signed ops; unsigned ops pass through.
  assign sgn_op = op_is_signed(op);
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];

  muldiv_abs_neg #(.W(WIDTH)) u_abs_a (.val(a), .neg(sa), .res(a_mag));
  muldiv_abs_neg #(.W(WIDTH)) u_abs_b (.val(b), .neg(sb), .res(b_mag));

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = ~op_is_div(op);
`else
  assign fast_mul = 1'b0;
`endif

  // Multiply step: add the multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dsr};
  assign mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide step: shift {rem,quo} left one bit; the shifted remainder needs
  // WIDTH+1 bits for the trial compare. A zero divisor always succeeds, which
  // yields an all-ones quotient and leaves the dividend in the remainder.
  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign div_ok  = rem_sh >= {1'b0, dsr};
  assign rem_sub = rem_sh[WIDTH-1:0] - dsr;
  assign div_nxt = div_ok ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  muldiv_abs_neg #(.W(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_q), .res(prod_res));
  muldiv_abs_neg #(.W(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(neg_q), .res(quo_res));
  muldiv_abs_neg #(.W(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(rem_res));

  // State register.
  always_ff @(posedge clka) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = fast_mul ? ST_SIGN : ST_CALC;
      ST_CALC: if (cnt == CNT_W'(1)) state_nxt = ST_SIGN;
      ST_SIGN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Datapath: operand capture, iteration, and HI/LO write-back with done pulse.
  always_ff @(posedge clka) begin
    if (rst) begin
      op_r  <= 2'b00;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dsr   <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            op_r  <= op;
            // Divide by zero keeps an all-ones quotient regardless of signs.
            neg_q <= (sa ^ sb) & (b != '0);
            neg_r <= sa;
            cnt   <= CNT_W'(WIDTH);
            if (op_is_div(op)) begin
              dsr <= b_mag;
              acc <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              dsr <= a_mag;
`ifdef MULDIV_FAST_MUL_EN
              acc <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
              acc <= {{WIDTH{1'b0}}, b_mag};
`endif
            end
          end
        end
        ST_CALC: begin
          acc <= op_is_div(op_r) ? div_nxt : mul_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        ST_SIGN: begin
          if (!flush) begin
            done <= 1'b1;
            if (op_is_div(op_r)) begin
              hi <= rem_res;
              lo <= quo_res;
            end else begin
              hi <= prod_res[2*WIDTH-1:WIDTH];
              lo <= prod_res[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (WIDTH=32): reset values, each opcode,
// divide-by-zero and signed overflow, back-to-back issue on the done cycle,
// ignored start while busy, and flush abort.
module tb_muldiv_iter_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ELAT_MUL = 2;
  localparam int STRT2    = 1;
`else
  localparam int ELAT_MUL = 34;
  localparam int STRT2    = 5;
`endif
  localparam int ELAT_DIV = 34;

  logic        clka, rst, start, flush, stall, done;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;

  int vectors     = 0;
  int miscompares = 0;

  muldiv_iter_unit #(.WIDTH(32)) dut (
    .clka (clka),
    .rst  (rst),
    .start(start),
    .op   (op),
    .flush(flush),
    .a    (a),
    .b    (b),
    .stall(stall),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues an op at the current negedge (cycle 0) and follows it to done.
  // Returns at the negedge of the done cycle with start low.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi,
                     input logic [31:0] elo, input int elat);
    int lat;
    logic stall_ok;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    stall_ok = (stall === 1'b1);
    @(negedge clka);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clka);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int lat;
    int extra;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clka);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clka);

    // Back-to-back: each issue lands in the previous op's done cycle.
    run("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, ELAT_MUL);
    run("divu",       OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, ELAT_DIV);
    run("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, ELAT_DIV);
    run("div_mixed",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, ELAT_DIV);
    run("divu_zero",  OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, ELAT_DIV);
    run("div_zero_n", OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, ELAT_DIV);
    run("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, ELAT_DIV);
    run("mult_minmin",OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, ELAT_MUL);
    run("mult_6x7",   OP_MULT,  32'd6,        32'd7,        32'h00000000, 32'h0000002A, ELAT_MUL);
    run("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ELAT_MUL);

    // A second start while busy must be ignored.
    start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clka);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clka);
      lat++;
      start = (lat == STRT2);
      if (lat == STRT2) begin
        op = OP_MULT; a = 32'd2; b = 32'd3;
      end
    end
    start = 1'b0;
    chk("busy_start_lat", 64'(lat), 64'(ELAT_MUL));
    chk("busy_start_hi", 64'(hi), 64'hFFFFFFFE);
    chk("busy_start_lo", 64'(lo), 64'h00000001);
    extra = 0;
    repeat (40) begin
      @(negedge clka);
      if (done === 1'b1) extra++;
    end
    chk("busy_start_no_extra_done", 64'(extra), 64'd0);
    chk("busy_start_hi_kept", 64'(hi), 64'hFFFFFFFE);

    // Flush in cycle 10 aborts a divide: no done, HI/LO untouched.
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clka);
    start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clka);
      lat++;
    end
    flush = 1'b1;
    @(negedge clka);
    flush = 1'b0;
    #1;
    chk("flush_stall_c11", 64'(stall), 64'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clka);
      if (done === 1'b1) extra++;
    end
    chk("flush_no_done", 64'(extra), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'hFFFFFFFE);
    chk("flush_lo_kept", 64'(lo), 64'h00000001);

    // Flush overrides start in IDLE: nothing is issued.
    start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    #1;
    chk("flush_start_stall", 64'(stall), 64'd0);
    @(negedge clka);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_idle", 64'(stall), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the execute stage of the 5-stage MIPS pipeline.
- Implements MULT, MULTU, DIV and DIVU using a shared radix-2 shift-add / restoring-subtract engine.
- Holds the HI/LO result registers.
- Drives a stall to the hazard unit while busy, and aborts on execute-stage flush.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits wide.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clka  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  issue request from the execute stage; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- flush  in  1  execute-stage flush; aborts any operation in progress.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- stall  out  1  combinational: (state!=IDLE) | (start & ~flush & state==IDLE).
- done  out  1  registered single-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset:
  - state=IDLE.
  - hi=0, lo=0, done=0, counter=0, internal accumulators=0.
  - stall=0 unless start is high.
- States: IDLE, CALC, SIGN.
- IDLE:
  - On start & ~flush: latch op, |a|, |b| and the sign flags, go to CALC.
  - Magnitudes (abs) are used only for signed ops; unsigned ops latch a and b unchanged.
  - The sign flags record the result sign and the remainder sign.
  - Counter loads WIDTH.
- CALC, one iteration per cycle for WIDTH cycles; the counter decrements and CALC exits to SIGN when it reaches 1.
  - Multiply: a 2*WIDTH accumulator shifts right; it adds the multiplicand when the current multiplier LSB is 1.
  - Divide: restoring step. Shift {rem,quo} left, then rem_trial=rem-divisor. If there is no borrow, keep the result and set the quotient LSB.
- SIGN (1 cycle):
  - Negate the product, quotient and remainder as required. The remainder takes the sign of the dividend. The quotient is negated when the operand signs differ.
  - Load hi/lo at the clock edge, set done for the next cycle, go to IDLE.
- Latency, with start in cycle 0:
  - CALC runs in cycles 1..WIDTH.
  - SIGN is cycle WIDTH+1.
  - done=1 and new hi/lo appear in cycle WIDTH+2; stall=0 in that cycle unless a new start arrives.
- All arithmetic is modulo 2^WIDTH per half. The signed multiply result is the full 2*WIDTH two's-complement product.
- Divide by zero (b==0):
  - Takes the full latency.
  - lo=all-ones and hi=a, for both signed and unsigned ops.
- Signed overflow case (most-negative value / -1): lo=most-negative value, hi=0, with no exception.
- start is ignored while state!=IDLE. done may coincide with a new start in IDLE; the new start is accepted.
- flush in any state:
  - Next state=IDLE.
  - No done pulse; hi/lo are unchanged.
  - flush overrides start in the same cycle.
- rst overrides flush and start.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MULT and MULTU compute the product combinationally at issue, skip CALC and go IDLE->SIGN.
  - done arrives in cycle 2.
  - Divides are unchanged.
- MULDIV_FAST_MUL_EN undefined: all ops iterate, with done in cycle WIDTH+2.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding ST_IDLE, ST_CALC, ST_SIGN.
- One sub-module: muldiv_abs_neg, a combinational parametrised conditional two's-complement negate.
  - Instanced for operand magnitude at issue.
  - Instanced for sign fix-up in SIGN.

Test Plan (WIDTH=32, start in cycle 0):
- MULT a=-3 (FFFFFFFD), b=7 -> done in cycle 34; hi=FFFFFFFF, lo=FFFFFFEB; stall high in cycles 0..33.
- DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
- DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678; still 34-cycle latency.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- MULTU FFFFFFFF*FFFFFFFF again with a second start in cycle 5 -> first result unchanged and no extra done; flush asserted in cycle 10 -> no done, hi/lo keep prior values, stall=0 in cycle 11.
- With MULDIV_FAST_MUL_EN: MULT 6*7 -> done in cycle 2, hi=0, lo=0000002A.
